// File: rtl/mult_pkg.sv
// mult_pkg: op encodings, op-width constant and small helpers shared by the
// mult_cell_pipe slice (mult_cell_pp and mult_cell_pipe).
package mult_pkg;

  localparam int OP_W = 2;

  localparam logic [OP_W-1:0] OP_MUL    = 2'b00;  // low word of the product
  localparam logic [OP_W-1:0] OP_MULXUU = 2'b01;  // high word, unsigned x unsigned
  localparam logic [OP_W-1:0] OP_MULXSU = 2'b10;  // high word, signed A x unsigned B
  localparam logic [OP_W-1:0] OP_MULXSS = 2'b11;  // high word, signed x signed

  // Half-word width used to split each operand into two unsigned halves.
  function automatic int half_w(input int width);
    return width / 2;
  endfunction

  // Operand A is interpreted as signed for these ops.
  function automatic logic op_signed_a(input logic [OP_W-1:0] op);
    return (op == OP_MULXSU) || (op == OP_MULXSS);
  endfunction

  // Operand B is interpreted as signed only for MULXSS.
  function automatic logic op_signed_b(input logic [OP_W-1:0] op);
    return (op == OP_MULXSS);
  endfunction

endpackage

// File: rtl/mult_cell_pp.sv
// mult_cell_pp: stage-1 partial-product register bank. Splits both operands
// into unsigned halves and registers the four HALF x HALF products when
// en_i is high. Pure datapath: no reset, no valid tracking.
module mult_cell_pp
  import mult_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             en_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] pp_ll_o,
  output logic [WIDTH-1:0] pp_lh_o,
  output logic [WIDTH-1:0] pp_hl_o,
  output logic [WIDTH-1:0] pp_hh_o
);

  localparam int HALF = half_w(WIDTH);

  logic [HALF-1:0]  a_lo, a_hi, b_lo, b_hi;
  logic [WIDTH-1:0] pp_ll_d, pp_lh_d, pp_hl_d, pp_hh_d;
  logic [WIDTH-1:0] pp_ll_q, pp_lh_q, pp_hl_q, pp_hh_q;

  assign a_lo = a_i[HALF-1:0];
  assign a_hi = a_i[WIDTH-1:HALF];
  assign b_lo = b_i[HALF-1:0];
  assign b_hi = b_i[WIDTH-1:HALF];

  // Zero-extend each half to full width so every product is exact.
  assign pp_ll_d = {{HALF{1'b0}}, a_lo} * {{HALF{1'b0}}, b_lo};
  assign pp_lh_d = {{HALF{1'b0}}, a_lo} * {{HALF{1'b0}}, b_hi};
  assign pp_hl_d = {{HALF{1'b0}}, a_hi} * {{HALF{1'b0}}, b_lo};
  assign pp_hh_d = {{HALF{1'b0}}, a_hi} * {{HALF{1'b0}}, b_hi};

  // Capture the four partial products whenever the pipeline advances.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement or block ordering.
  // NOTE: datapath flops carry no reset; the valid bits alone say whether
  // their contents mean anything, so resetting them would only cost routing.
  always_ff @(posedge clk) begin
    if (en_i) begin
      pp_ll_q <= pp_ll_d;
      pp_lh_q <= pp_lh_d;
      pp_hl_q <= pp_hl_d;
      pp_hh_q <= pp_hh_d;
    end
  end

  assign pp_ll_o = pp_ll_q;
  assign pp_lh_o = pp_lh_q;
  assign pp_hl_o = pp_hl_q;
  assign pp_hh_o = pp_hh_q;

endmodule

// File: rtl/mult_cell_pipe.sv
// mult_cell_pipe: pipelined WIDTH x WIDTH multiplier cell with valid/ready
// handshake, sideband tag, synchronous flush and async active-high reset.
//   stage 1: four registered partial products (mult_cell_pp) + op/tag/operands
//   stage 2: full 2*WIDTH unsigned product + signed-correction terms + op/tag
//   result : selected word, combinational from stage 2 (latency 2), or from a
//            stage-3 flop when MULT_CELL_PIPE_OUTREG_EN is defined (latency 3).
// The whole pipeline moves together on advance = !out_valid || out_ready.
module mult_cell_pipe
  import mult_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] src1,
  input  logic [WIDTH-1:0] src2,
  input  logic [OP_W-1:0]  op,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [TAG_W-1:0] out_tag
);

  localparam int HALF = half_w(WIDTH);

  logic advance;

  // Per-stage valid bits (the only reset state in the cell).
  logic s1_valid_q, s1_valid_d;
  logic s2_valid_q, s2_valid_d;

  // Stage-1 datapath.
  logic [WIDTH-1:0] s1_a_q, s1_b_q;
  logic [OP_W-1:0]  s1_op_q;
  logic [TAG_W-1:0] s1_tag_q;
  logic [WIDTH-1:0] pp_ll, pp_lh, pp_hl, pp_hh;

  // Stage-2 datapath.
  logic [2*WIDTH-1:0] prod_d, s2_prod_q;
  logic [WIDTH-1:0]   corr_a_d, corr_b_d;
  logic [WIDTH-1:0]   s2_corr_a_q, s2_corr_b_q;
  logic [OP_W-1:0]    s2_op_q;
  logic [TAG_W-1:0]   s2_tag_q;

  // Result selection.
  logic [WIDTH-1:0] prod_lo, prod_hi, sel_result;

`ifdef MULT_CELL_PIPE_OUTREG_EN
  logic             s3_valid_q, s3_valid_d;
  logic [WIDTH-1:0] s3_result_q;
  logic [TAG_W-1:0] s3_tag_q;
`endif

  // A stalled output freezes every stage; flush also blocks new work.
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance && !flush;

  // Next-state of the valid bits: flush empties the pipe even while stalled.
  // NOTE: every variable driven here gets its hold value first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s2_valid_d = s2_valid_q;
`ifdef MULT_CELL_PIPE_OUTREG_EN
    s3_valid_d = s3_valid_q;
`endif
    if (flush) begin
      s1_valid_d = 1'b0;
      s2_valid_d = 1'b0;
`ifdef MULT_CELL_PIPE_OUTREG_EN
      s3_valid_d = 1'b0;
`endif
    end else if (advance) begin
      // in_ready == advance here, so an offered op is accepted.
      s1_valid_d = in_valid;
      s2_valid_d = s1_valid_q;
`ifdef MULT_CELL_PIPE_OUTREG_EN
      s3_valid_d = s2_valid_q;
`endif
    end
  end

  // Valid-bit registers, cleared asynchronously so in-flight ops are lost.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
`ifdef MULT_CELL_PIPE_OUTREG_EN
      s3_valid_q <= 1'b0;
`endif
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
`ifdef MULT_CELL_PIPE_OUTREG_EN
      s3_valid_q <= s3_valid_d;
`endif
    end
  end

  // Stage 1: partial products live in the sub-module.
  mult_cell_pp #(
    .WIDTH (WIDTH)
  ) u_pp (
    .clk     (clk),
    .en_i    (advance),
    .a_i     (src1),
    .b_i     (src2),
    .pp_ll_o (pp_ll),
    .pp_lh_o (pp_lh),
    .pp_hl_o (pp_hl),
    .pp_hh_o (pp_hh)
  );

  // Stage 1: operands (for sign correction), op and tag ride alongside.
  always_ff @(posedge clk) begin
    if (advance) begin
      s1_a_q   <= src1;
      s1_b_q   <= src2;
      s1_op_q  <= op;
      s1_tag_q <= in_tag;
    end
  end

  // Recombine the partial products into the exact unsigned 2*WIDTH product;
  // the true product is < 2^(2*WIDTH), so the sum never overflows.
  assign prod_d = {{WIDTH{1'b0}}, pp_ll}
                + ({{WIDTH{1'b0}}, pp_lh} << HALF)
                + ({{WIDTH{1'b0}}, pp_hl} << HALF)
                + {pp_hh, {WIDTH{1'b0}}};

  // Signed high word = unsigned high word minus B if A is negative (signed A)
  // and minus A if B is negative (signed B), modulo 2^WIDTH.
  assign corr_a_d = (op_signed_a(s1_op_q) && s1_a_q[WIDTH-1]) ? s1_b_q : '0;
  assign corr_b_d = (op_signed_b(s1_op_q) && s1_b_q[WIDTH-1]) ? s1_a_q : '0;

  // Stage 2: product, correction terms, op and tag.
  always_ff @(posedge clk) begin
    if (advance) begin
      s2_prod_q   <= prod_d;
      s2_corr_a_q <= corr_a_d;
      s2_corr_b_q <= corr_b_d;
      s2_op_q     <= s1_op_q;
      s2_tag_q    <= s1_tag_q;
    end
  end

  assign prod_lo = s2_prod_q[WIDTH-1:0];
  assign prod_hi = s2_prod_q[2*WIDTH-1:WIDTH];

  // Pick the low word for MUL, otherwise the (sign-corrected) high word.
  always_comb begin
    sel_result = prod_hi - s2_corr_a_q - s2_corr_b_q;
    if (s2_op_q == OP_MUL) begin
      sel_result = prod_lo;
    end
  end

`ifdef MULT_CELL_PIPE_OUTREG_EN
  // Stage 3: registered result and tag.
  always_ff @(posedge clk) begin
    if (advance) begin
      s3_result_q <= sel_result;
      s3_tag_q    <= s2_tag_q;
    end
  end

  assign out_valid = s3_valid_q;
  assign result    = s3_result_q;
  assign out_tag   = s3_tag_q;
`else
  assign out_valid = s2_valid_q;
  assign result    = sel_result;
  assign out_tag   = s2_tag_q;
`endif

endmodule

// File: tb/tb_mult_cell_pipe.sv
// tb_mult_cell_pipe: self-checking bench for mult_cell_pipe (WIDTH=32).
// Honours MULT_CELL_PIPE_OUTREG_EN for the expected latency.
module tb_mult_cell_pipe;
  import mult_pkg::*;

  localparam int WIDTH  = 32;
  localparam int TAG_W  = 5;
  localparam int N_RAND = 10000;
`ifdef MULT_CELL_PIPE_OUTREG_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  logic             clk = 1'b0;
  logic             reset, flush, in_valid, in_ready, out_valid, out_ready;
  logic [WIDTH-1:0] src1, src2, result;
  logic [OP_W-1:0]  op;
  logic [TAG_W-1:0] in_tag, out_tag;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  mult_cell_pipe #(
    .WIDTH (WIDTH),
    .TAG_W (TAG_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .src1      (src1),
    .src2      (src2),
    .op        (op),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .out_tag   (out_tag)
  );

  typedef struct {
    string            name;
    logic [OP_W-1:0]  op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] exp;
  } vec_t;

  localparam int NV = 15;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  // Reference: interpret operands as signed/unsigned per op, multiply as
  // 2*WIDTH-bit integers, take the requested word.
  function automatic logic [WIDTH-1:0] ref_model(input logic [OP_W-1:0] f_op,
                                                 input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b);
    logic signed [2*WIDTH-1:0] ea, eb, p;
    ea = (f_op == OP_MULXSU || f_op == OP_MULXSS) ? {{WIDTH{a[WIDTH-1]}}, a}
                                                  : {{WIDTH{1'b0}}, a};
    eb = (f_op == OP_MULXSS) ? {{WIDTH{b[WIDTH-1]}}, b} : {{WIDTH{1'b0}}, b};
    p  = ea * eb;
    return (f_op == OP_MUL) ? p[WIDTH-1:0] : p[2*WIDTH-1:WIDTH];
  endfunction

  function automatic logic [WIDTH-1:0] rand_operand();
    case ($urandom_range(7))
      0:       return '0;
      1:       return '1;
      2:       return {1'b1, {(WIDTH-1){1'b0}}};
      3:       return {1'b0, {(WIDTH-1){1'b1}}};
      default: return $urandom;
    endcase
  endfunction

  // Offer one op with out_ready high, then measure latency, result and tag.
  task automatic run_one(input string name, input logic [OP_W-1:0] t_op,
                         input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic [TAG_W-1:0] tag, input logic [WIDTH-1:0] exp);
    int waited;
    int lat;
    op = t_op; src1 = a; src2 = b; in_tag = tag;
    in_valid = 1'b1; out_ready = 1'b1;
    waited = 0;
    @(negedge clk);
    while (!in_ready && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      check({name, " in_ready"}, 32'(in_ready), 32'd1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!out_valid && lat < 10);
    check({name, " latency"}, 32'(lat), 32'(LAT));
    check({name, " result"}, result, exp);
    check({name, " tag"}, 32'(out_tag), 32'(tag));
    @(posedge clk);
    #1;
  endtask

  // Four back-to-back ops; output stalls for 3 cycles after the first result.
  task automatic stall_test();
    logic [WIDTH-1:0] exp_q[$];
    logic [TAG_W-1:0] tag_q[$];
    logic [WIDTH-1:0] a, b;
    int sent = 0, got = 0, stall_left = 0, cyc = 0;
    bit first_seen = 0;
    while (got < 4 && cyc < 40) begin
      a = (sent % 2 == 1) ? 32'h8765_4321 : 32'h1357_9BDF;
      b = 32'hF00D_0000 ^ 32'(sent * 32'h0101_0101);
      if (sent < 4) begin
        in_valid = 1'b1; op = OP_W'(sent); src1 = a; src2 = b;
        in_tag = TAG_W'(sent + 1);
      end else begin
        in_valid = 1'b0;
      end
      out_ready = (stall_left == 0);
      @(negedge clk);
      if (!out_ready) begin
        check("stall in_ready", 32'(in_ready), 32'd0);
        check("stall out_valid", 32'(out_valid), 32'd1);
        stall_left--;
      end
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check("stall spurious out_valid", 32'(out_valid), 32'd0);
        end else begin
          check("stall result", result, exp_q[0]);
          check("stall tag", 32'(out_tag), 32'(tag_q[0]));
          if (out_ready) begin
            void'(exp_q.pop_front());
            void'(tag_q.pop_front());
            got++;
            if (!first_seen) begin
              first_seen = 1;
              stall_left = 3;
            end
          end
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(ref_model(OP_W'(sent), a, b));
        tag_q.push_back(TAG_W'(sent + 1));
        sent++;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    check("stall delivered count", 32'(got), 32'd4);
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("stall no duplicate", 32'(out_valid), 32'd0);
    end
    @(posedge clk);
    #1;
  endtask

  // Accept two ops into the pipe (caller sets out_ready).
  task automatic load_two(input string name);
    for (int k = 0; k < 2; k++) begin
      in_valid = 1'b1; op = OP_MUL; src1 = 32'(k + 11); src2 = 32'd3;
      in_tag = TAG_W'(20 + k);
      @(negedge clk);
      check({name, " accept"}, 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic flush_test();
    out_ready = 1'b0;
    load_two("flush");
    flush = 1'b1; in_valid = 1'b1; op = OP_MUL; src1 = 32'd9; src2 = 32'd9;
    in_tag = TAG_W'(7);
    @(negedge clk);
    check("flush in_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1 flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (6) begin
      @(negedge clk);
      check("flush out_valid", 32'(out_valid), 32'd0);
    end
    @(posedge clk);
    #1;
    run_one("post-flush", OP_MUL, 32'd6, 32'd7, TAG_W'(9), 32'd42);
  endtask

  task automatic reset_test();
    out_ready = 1'b1;
    load_two("reset");
    reset = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    check("mid reset out_valid", 32'(out_valid), 32'd0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("post reset in_ready", 32'(in_ready), 32'd1);
    repeat (6) begin
      @(negedge clk);
      check("post reset out_valid", 32'(out_valid), 32'd0);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic random_test();
    logic [WIDTH-1:0] rq[$];
    logic [TAG_W-1:0] tq[$];
    logic [WIDTH-1:0] a, b;
    logic [OP_W-1:0]  r_op;
    int acc = 0, cyc = 0;
    while ((acc < N_RAND || rq.size() > 0) && cyc < 60000) begin
      a = rand_operand(); b = rand_operand(); r_op = OP_W'($urandom_range(3));
      src1 = a; src2 = b; op = r_op; in_tag = TAG_W'($urandom);
      in_valid  = (acc < N_RAND) && ($urandom_range(3) != 0);
      out_ready = (acc >= N_RAND) || ($urandom_range(2) != 0);
      @(negedge clk);
      check("rand in_ready", 32'(in_ready), 32'(!(out_valid && !out_ready)));
      if (out_valid) begin
        if (rq.size() == 0) begin
          check("rand spurious out_valid", 32'(out_valid), 32'd0);
        end else begin
          check("rand result", result, rq[0]);
          check("rand tag", 32'(out_tag), 32'(tq[0]));
          if (out_ready) begin
            void'(rq.pop_front());
            void'(tq.pop_front());
          end
        end
      end
      if (in_valid && in_ready) begin
        rq.push_back(ref_model(r_op, a, b));
        tq.push_back(in_tag);
        acc++;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    check("rand accepted", 32'(acc), 32'(N_RAND));
    check("rand drained", 32'(rq.size()), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{"ones MUL",     OP_MUL,    32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001};
    vecs[1]  = '{"ones MULXUU",  OP_MULXUU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
    vecs[2]  = '{"ones MULXSU",  OP_MULXSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    vecs[3]  = '{"ones MULXSS",  OP_MULXSS, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000};
    vecs[4]  = '{"min MULXSS",   OP_MULXSS, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000};
    vecs[5]  = '{"min MULXSU",   OP_MULXSU, 32'h8000_0000, 32'h8000_0000, 32'hC000_0000};
    vecs[6]  = '{"min MULXUU",   OP_MULXUU, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000};
    vecs[7]  = '{"mixed MUL",    OP_MUL,    32'h0001_0003, 32'h0002_0005, 32'h000B_000F};
    vecs[8]  = '{"mixed MULXUU", OP_MULXUU, 32'h0001_0003, 32'h0002_0005, 32'h0000_0002};
    vecs[9]  = '{"neg2x3 MUL",   OP_MUL,    32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFA};
    vecs[10] = '{"neg2x3 MULXSU",OP_MULXSU, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF};
    vecs[11] = '{"3xmin MULXSU", OP_MULXSU, 32'h0000_0003, 32'h8000_0000, 32'h0000_0001};
    vecs[12] = '{"3xmin MULXSS", OP_MULXSS, 32'h0000_0003, 32'h8000_0000, 32'hFFFF_FFFE};
    vecs[13] = '{"zero MUL",     OP_MUL,    32'h0000_0000, 32'h1234_5678, 32'h0000_0000};
    vecs[14] = '{"max MULXSS",   OP_MULXSS, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF};

    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    src1 = '0; src2 = '0; op = OP_MUL; in_tag = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset out_valid", 32'(out_valid), 32'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("after reset in_ready", 32'(in_ready), 32'd1);
    check("after reset out_valid", 32'(out_valid), 32'd0);

    for (int i = 0; i < NV; i++) begin
      run_one(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, TAG_W'(i + 1), vecs[i].exp);
    end

    stall_test();
    flush_test();
    reset_test();
    random_test();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mult_cell_pipe.md
MULT_CELL_PIPE -- requirements
Module: mult_cell_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width; even, 8..64.
REQ-002 SHALL have parameter TAG_W, default 5, width of sideband tag (destination register id) carried alongside each operation.
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port flush  input  1  synchronous discard of all in-flight operations.
REQ-006 SHALL have port in_valid  input  1  operation offered.
REQ-007 SHALL have port in_ready  output  1  operation accepted when in_valid&&in_ready.
REQ-008 SHALL have port src1  input  WIDTH  operand A.
REQ-009 SHALL have port src2  input  WIDTH  operand B.
REQ-010 SHALL have port op  input  2  00 MUL (low word), 01 MULXUU, 10 MULXSU (A signed, B unsigned), 11 MULXSS (high words).
REQ-011 SHALL have port in_tag  input  TAG_W  sideband tag.
REQ-012 SHALL have port out_valid  output  1  result available.
REQ-013 SHALL have port out_ready  input  1  result consumed when out_valid&&out_ready.
REQ-014 SHALL have port result  output  WIDTH  selected result word.
REQ-015 SHALL have port out_tag  output  TAG_W  tag of the operation in result.

Function
REQ-016 SHALL split each operand into HALF=WIDTH/2 halves, form four HALF x HALF unsigned partial products (ll, lh, hl, hh) and register them in stage 1.
REQ-017 SHALL sum partial products into the full 2*WIDTH unsigned product, registered in stage 2 with op and tag.
REQ-018 SHALL select: MUL -> product[WIDTH-1:0]; MULXUU -> product[2W-1:W]; MULXSU -> high minus (A[W-1]?B:0); MULXSS -> high minus (A[W-1]?B:0) minus (B[W-1]?A:0), all mod 2^WIDTH.
REQ-019 SHALL give latency 2 cycles from acceptance to out_valid with no stall (macro absent).
REQ-020 SHALL advance whole pipeline only when advance = !out_valid || out_ready; in_ready SHALL equal advance.
REQ-021 SHALL hold all stage contents, result and out_tag stable while out_valid&&!out_ready.
REQ-022 SHALL accept one operation per cycle sustained when out_ready held high (full throughput, no bubbles).
REQ-023 SHALL propagate per-stage valid bits; empty stages SHALL not assert out_valid.
REQ-024 SHALL, on flush, clear every stage valid bit next edge, regardless of stall; an operation offered in the flush cycle SHALL be dropped; in_ready SHALL be 0 during flush.
REQ-025 SHALL keep datapath registers free of reset; only valid bits are reset.

Reset
REQ-026 SHALL, while reset high, force all valid bits to 0: out_valid=0, in_ready=1 the cycle after reset deasserts.
REQ-027 SHALL discard operations in flight when reset asserts mid-operation; no result SHALL emerge afterwards.

Configuration
REQ-028 SHALL, with MULT_CELL_PIPE_OUTREG_EN defined, add a stage-3 register after result selection: latency 3, result driven from a flop.
REQ-029 SHALL, without MULT_CELL_PIPE_OUTREG_EN, drive result combinationally from stage 2: latency 2; handshake rules unchanged.

Structure
REQ-030 SHALL take op encodings (OP_MUL, OP_MULXUU, OP_MULXSU, OP_MULXSS) and the op-width constant from shared package mult_pkg.
REQ-031 SHALL contain one sub-module mult_cell_pp computing the four registered partial products with enable; remaining logic in the top.

Verification (WIDTH=32)
REQ-032 SHALL check 0xFFFFFFFF x 0xFFFFFFFF: MUL -> 0x00000001, MULXUU -> 0xFFFFFFFE, MULXSU -> 0xFFFFFFFF, MULXSS -> 0x00000000.
REQ-033 SHALL check 0x80000000 x 0x80000000: MULXSS -> 0x40000000, MULXSU -> 0xC0000000, MULXUU -> 0x40000000.
REQ-034 SHALL check 4 back-to-back ops tags 1..4 with out_ready low 3 cycles after first out_valid -> in_ready low during stall, results/tags delivered in order, none lost or duplicated.
REQ-035 SHALL check flush asserted one cycle after accepting 2 ops -> out_valid stays 0; next op after flush emerges after nominal latency with correct value.
REQ-036 SHALL check reset pulse with 2 ops in flight -> out_valid 0 thereafter, in_ready 1 the cycle after release.
REQ-037 SHALL check 10k random operands/ops both macro settings against a 2*WIDTH reference model with random out_ready -> exact match, latency 2 or 3 as configured.
